// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART receive-side program loader.
// Deserialises an 8N1 byte stream, packs bytes little-endian into 32-bit
// words, writes them to instruction memory over a valid/ack port and holds
// the core in reset until the END_WORD terminator has been received.
// Optional even-parity framing: define UART_PROG_LOADER_PARITY_EN.
module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 347,
    parameter int unsigned ADDR_W       = 14,
    parameter logic [31:0] END_WORD     = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              rx_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    output logic              core_rst_l_o,
    output logic              prog_done_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              frame_err_o,
    output logic              overrun_err_o
`ifdef UART_PROG_LOADER_PARITY_EN
    ,
    output logic              parity_err_o
`endif
);

    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PROG_LOADER_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } rx_state_t;

    // synchroniser and receiver state
    logic              r_rx_meta;
    logic              r_rx_sync;
    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [15:0]       r_cnt;
    logic [15:0]       w_cnt_nxt;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              r_wait_high;
    logic              w_wait_nxt;
    logic              w_byte_valid;
    logic              w_frame_bad;
`ifdef UART_PROG_LOADER_PARITY_EN
    logic              r_par_fail;
    logic              w_par_fail_nxt;
    logic              w_par_bad;
    logic              r_parity_err;
`endif

    // word assembly and write port
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_term;
    logic              r_done;
    logic              r_frame_err;
    logic              r_overrun;
    logic              w_ack;
    logic              w_accept;
    logic              w_complete;
    logic [31:0]       w_full;

    // two-flop synchroniser, idle-high reset value
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    // receiver state and datapath registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_wait_high <= 1'b0;
`ifdef UART_PROG_LOADER_PARITY_EN
            r_par_fail  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_wait_high <= w_wait_nxt;
`ifdef UART_PROG_LOADER_PARITY_EN
            r_par_fail  <= w_par_fail_nxt;
`endif
        end
    end

    // receiver next-state, bit sampling and byte strobe
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 16'd1;
        w_bit_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift;
        w_wait_nxt   = r_wait_high;
        w_byte_valid = 1'b0;
        w_frame_bad  = 1'b0;
`ifdef UART_PROG_LOADER_PARITY_EN
        w_par_fail_nxt = r_par_fail;
        w_par_bad      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                // after a framing error the line must return high before re-arming
                if (r_wait_high) begin
                    if (r_rx_sync) w_wait_nxt = 1'b0;
                end else if (!r_rx_sync) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF_CNT) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
`ifdef UART_PROG_LOADER_PARITY_EN
                    w_par_fail_nxt = 1'b0;
`endif
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_PROG_LOADER_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_PROG_LOADER_PARITY_EN
            S_PARITY: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt      = '0;
                    w_par_bad      = ^{r_shift, r_rx_sync};
                    w_par_fail_nxt = w_par_bad;
                    w_state_nxt    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (r_rx_sync) begin
`ifdef UART_PROG_LOADER_PARITY_EN
                        w_byte_valid = !r_par_fail;
`else
                        w_byte_valid = 1'b1;
`endif
                    end else begin
                        w_frame_bad = 1'b1;
                        w_wait_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_ack      = r_we & mem_ack_i;
    assign w_accept   = w_byte_valid & ~r_term;
    assign w_complete = w_accept & (r_byte_idx == 2'd3);
    assign w_full     = {r_shift, r_word};

    // word assembly, write handshake, counters and sticky status
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_count      <= '0;
            r_term       <= 1'b0;
            r_done       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_PROG_LOADER_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (w_ack) begin
                r_we   <= 1'b0;
                r_addr <= r_addr + ADDR_W'(1);
                if (r_count != '1) r_count <= r_count + (ADDR_W+1)'(1);
            end
            if (w_accept) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_word[7:0]   <= r_shift;
                    2'd1:    r_word[15:8]  <= r_shift;
                    2'd2:    r_word[23:16] <= r_shift;
                    default: ;
                endcase
            end
            // an ack on the same edge frees the port, so the new word is taken
            if (w_complete) begin
                if (w_full == END_WORD) begin
                    r_term <= 1'b1;
                end else if (!r_we || w_ack) begin
                    r_wdata <= w_full;
                    r_we    <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            if (w_frame_bad && !r_done) r_frame_err <= 1'b1;
`ifdef UART_PROG_LOADER_PARITY_EN
            if (w_par_bad && !r_done) r_parity_err <= 1'b1;
`endif
            if (r_term && !r_we) r_done <= 1'b1;
        end
    end

    assign mem_we_o      = r_we;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = r_wdata;
    assign word_count_o  = r_count;
    assign prog_done_o   = r_done;
    assign core_rst_l_o  = r_done;
    assign frame_err_o   = r_frame_err;
    assign overrun_err_o = r_overrun;
`ifdef UART_PROG_LOADER_PARITY_EN
    assign parity_err_o  = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader (CLKS_PER_BIT=8, ADDR_W=2).
`timescale 1ns/1ps
module tb_uart_prog_loader;

    localparam int CPB = 8;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          rx_i = 1'b1;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic          core_rst_l_o;
    logic          prog_done_o;
    logic [AW:0]   word_count_o;
    logic          frame_err_o;
    logic          overrun_err_o;
`ifdef UART_PROG_LOADER_PARITY_EN
    logic          parity_err_o;
`endif

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .END_WORD     (32'hFFFF_FFFF)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .rx_i          (rx_i),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .core_rst_l_o  (core_rst_l_o),
        .prog_done_o   (prog_done_o),
        .word_count_o  (word_count_o),
        .frame_err_o   (frame_err_o),
        .overrun_err_o (overrun_err_o)
`ifdef UART_PROG_LOADER_PARITY_EN
        ,
        .parity_err_o  (parity_err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  ack_en   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor: pops the expected write whenever the DUT presents one and acks it
    always @(negedge clk) begin
        if (mem_we_o && ack_en && rst_l) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%h data=%h required=no write",
                         mem_addr_o, mem_wdata_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr_o), e.addr);
                check("wr_data", mem_wdata_o, e.data);
            end
            mem_ack_i = 1'b1;
        end else begin
            mem_ack_i = 1'b0;
        end
    end

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic uart_bit(input logic v);
        rx_i = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        uart_bit(1'b0);
        for (int i = 0; i < 8; i++) uart_bit(b[i]);
`ifdef UART_PROG_LOADER_PARITY_EN
        uart_bit(^b);
`endif
        uart_bit(stop_v);
        rx_i = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rst_we"},      32'(mem_we_o), 32'd0);
        check({tag, "_rst_addr"},    32'(mem_addr_o), 32'd0);
        check({tag, "_rst_wdata"},   mem_wdata_o, 32'd0);
        check({tag, "_rst_count"},   32'(word_count_o), 32'd0);
        check({tag, "_rst_corerst"}, 32'(core_rst_l_o), 32'd0);
        check({tag, "_rst_done"},    32'(prog_done_o), 32'd0);
        check({tag, "_rst_frame"},   32'(frame_err_o), 32'd0);
        check({tag, "_rst_overrun"}, 32'(overrun_err_o), 32'd0);
`ifdef UART_PROG_LOADER_PARITY_EN
        check({tag, "_rst_parity"},  32'(parity_err_o), 32'd0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rx_i   = 1'b1;
        ack_en = 1'b1;
        rst_l  = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_checks(tag);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // wait for every expected write to retire, bounded
    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || mem_we_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a0;
        logic [31:0]   d0;
        bit            stable;
        int            n;

        // basic load and terminator
        do_reset("basic");
        expect_write(32'd0, 32'h1234_5678);
        expect_write(32'd1, 32'hDEAD_BEEF);
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        drain("basic");
        check("basic_count", 32'(word_count_o), 32'd2);
        check("basic_done_early", 32'(prog_done_o), 32'd0);
        check("basic_corerst_early", 32'(core_rst_l_o), 32'd0);
        send_word(32'hFFFF_FFFF);
        n = 0;
        while (!prog_done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("basic_done", 32'(prog_done_o), 32'd1);
        check("basic_corerst", 32'(core_rst_l_o), 32'd1);
        check("basic_frame", 32'(frame_err_o), 32'd0);
        check("basic_overrun", 32'(overrun_err_o), 32'd0);
        // traffic after done is ignored; the monitor flags any write
        send_word(32'h0102_0304);
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check("postdone_count", 32'(word_count_o), 32'd2);
        check("postdone_we", 32'(mem_we_o), 32'd0);
        check("postdone_frame", 32'(frame_err_o), 32'd0);
        check("postdone_done", 32'(prog_done_o), 32'd1);

        // ack stall
        do_reset("stall");
        ack_en = 1'b0;
        expect_write(32'd0, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        n = 0;
        while (!mem_we_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_we", 32'(mem_we_o), 32'd1);
        a0 = mem_addr_o;
        d0 = mem_wdata_o;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!mem_we_o || mem_addr_o !== a0 || mem_wdata_o !== d0) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_addr", 32'(a0), 32'd0);
        check("stall_data", d0, 32'hCAFE_F00D);
        check("stall_count_pending", 32'(word_count_o), 32'd0);
        ack_en = 1'b1;
        drain("stall");
        check("stall_count", 32'(word_count_o), 32'd1);

        // overrun
        do_reset("ovr");
        ack_en = 1'b0;
        expect_write(32'd0, 32'h1111_1111);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        check("ovr_flag", 32'(overrun_err_o), 32'd1);
        ack_en = 1'b1;
        drain("ovr");
        repeat (10) @(negedge clk);
        check("ovr_count", 32'(word_count_o), 32'd1);
        check("ovr_we", 32'(mem_we_o), 32'd0);
        check("ovr_addr", 32'(mem_addr_o), 32'd1);

        // glitch then framing error then a clean word
        do_reset("frm");
        rx_i = 1'b0;
        repeat (2) @(negedge clk);
        rx_i = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_frame", 32'(frame_err_o), 32'd0);
        check("glitch_we", 32'(mem_we_o), 32'd0);
        send_byte(8'h55, 1'b0);
        check("frm_flag", 32'(frame_err_o), 32'd1);
        expect_write(32'd0, 32'h4433_2211);
        send_word(32'h4433_2211);
        drain("frm");
        check("frm_count", 32'(word_count_o), 32'd1);
        check("frm_overrun", 32'(overrun_err_o), 32'd0);

        // address wrap
        do_reset("wrap");
        for (int i = 0; i < 5; i++) begin
            expect_write(32'(i % 4), 32'hA000_0000 + 32'(i));
            send_word(32'hA000_0000 + 32'(i));
        end
        drain("wrap");
        check("wrap_count", 32'(word_count_o), 32'd5);
        check("wrap_addr_next", 32'(mem_addr_o), 32'd1);

        // reset in the middle of DATA bit 3 of the third byte
        do_reset("mid");
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        begin
            logic [7:0] b;
            b = 8'hCC;
            uart_bit(1'b0);
            for (int i = 0; i < 3; i++) uart_bit(b[i]);
            rx_i = b[3];
        end
        repeat (CPB / 2) @(negedge clk);
        rst_l = 1'b0;
        repeat (2) @(negedge clk);
        reset_checks("mid");
        rx_i  = 1'b1;
        rst_l = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        expect_write(32'd0, 32'h0D0C_0B0A);
        send_word(32'h0D0C_0B0A);
        drain("mid");
        check("mid_count", 32'(word_count_o), 32'd1);

`ifdef UART_PROG_LOADER_PARITY_EN
        // bad parity on 0x03 (even parity would be 0)
        do_reset("par");
        begin
            logic [7:0] b;
            b = 8'h03;
            uart_bit(1'b0);
            for (int i = 0; i < 8; i++) uart_bit(b[i]);
            uart_bit(1'b1);
            uart_bit(1'b1);
            repeat (CPB) @(negedge clk);
        end
        check("par_flag", 32'(parity_err_o), 32'd1);
        expect_write(32'd0, 32'h8765_4321);
        send_word(32'h8765_4321);
        drain("par");
        check("par_count", 32'(word_count_o), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART receive-side program loader inside the user project.
- Deserialises the byte stream that the bench programmer drives on mprj_io[5].
- Assembles bytes little-endian into 32-bit words and writes them to the core's instruction memory through a valid/ack write port.
- Holds the BrqRV core in reset until the end-of-program marker word arrives.

Parameters:
- CLKS_PER_BIT, 347, clk cycles per UART bit (40 MHz / 115200); legal range 4 to 65535
- ADDR_W, 14, word-address width of the instruction memory
- END_WORD, 32'hFFFF_FFFF, terminator word; it is never written to memory

Ports:
- clk  in  1  system clock
- rst_l  in  1  reset, asynchronous assert, active low
- rx_i  in  1  UART serial input, idle high
- mem_we_o  out  1  write request; held until acknowledged
- mem_addr_o  out  ADDR_W  word address of the write
- mem_wdata_o  out  32  write data
- mem_ack_i  in  1  memory accepts the write on the clk edge where mem_we_o=1 and mem_ack_i=1
- core_rst_l_o  out  1  core reset; low until load done
- prog_done_o  out  1  terminator received and last write retired
- word_count_o  out  ADDR_W+1  number of words written
- frame_err_o  out  1  sticky, stop-bit error seen
- overrun_err_o  out  1  sticky, word dropped because a write was pending

Behaviour:
- Reset is one clock, asynchronous, active low. While rst_l=0:
  - mem_we_o, prog_done_o, core_rst_l_o, frame_err_o and overrun_err_o are 0.
  - mem_addr_o, mem_wdata_o and word_count_o are 0.
  - The RX FSM is in IDLE and the byte index is 0.
- Reset mid-frame or mid-write aborts everything. There is no partial-word retention.
- rx_i passes through a 2-flop synchroniser; both flops reset to 1.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: go to START on synchronised rx = 0; the bit counter is cleared.
  - START: at count CLKS_PER_BIT/2 (integer divide), sample rx. If rx = 1 it is a glitch: return to IDLE with no error. If rx = 0, go to DATA with the counter cleared.
  - DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first. After bit 7 go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx = 1: the byte is valid for one cycle. Return to IDLE.
    - rx = 0: set frame_err_o, discard the byte, and wait in IDLE for rx = 1 before re-arming. This prevents a break from retriggering.
- Word assembly:
  - A valid byte is placed at lane byte_idx, so byte 0 goes to [7:0].
  - byte_idx increments modulo 4. On the 4th byte the word is complete.
- Word completion:
  - Complete word == END_WORD: set a terminate flag. It is not written.
  - Otherwise, if mem_we_o = 0: load mem_wdata_o, raise mem_we_o next cycle, with mem_addr_o = current write address.
  - Otherwise (write still pending): set overrun_err_o and drop the word. The address does not advance.
- Write handshake:
  - mem_we_o, mem_addr_o and mem_wdata_o stay stable until the mem_ack_i edge.
  - On ack: mem_we_o drops, the address increments, and word_count_o increments.
  - The address wraps from 2^ADDR_W-1 to 0. word_count_o saturates at 2^(ADDR_W+1)-1.
  - An ack in the same cycle as a new word completing counts as retired, so the new word is accepted with no overrun.
- Done:
  - Once terminate is set and mem_we_o = 0, prog_done_o = 1 and core_rst_l_o = 1 on the next edge.
  - Both stay high until rst_l.
  - After done, further rx traffic is ignored: no writes, and no error flags change.
- Errors do not block loading. The flags are observational only.

Optional Feature:
- Macro UART_PROG_LOADER_PARITY_EN.
- When defined:
  - The frame carries an even-parity bit after data bit 7, sampled one bit period after bit 7, and STOP follows it.
  - On a mismatch the sticky parity_err_o (out, 1, reset 0) is set and the byte is discarded; byte_idx does not advance.
- When undefined:
  - Frames are 8N1 and the parity_err_o port is absent.

Test Plan:
- Basic load, CLKS_PER_BIT=8: send bytes 78 56 34 12 EF BE AD DE then FF FF FF FF.
  - Expect writes (addr 0, 32'h1234_5678) and (addr 1, 32'hDEAD_BEEF).
  - Expect word_count_o = 2, then prog_done_o = 1 and core_rst_l_o = 1 one cycle after the last ack.
- Ack stall: hold mem_ack_i = 0 for 20 cycles after mem_we_o rises.
  - Expect addr and data stable throughout, one write retired, count = 1.
- Overrun: keep mem_ack_i = 0 and send two full words.
  - Expect overrun_err_o = 1, only the first word written once ack is released, count = 1.
- Framing and glitch:
  - Send 0x55 with stop bit = 0: expect frame_err_o = 1 and byte_idx unchanged.
  - Send a 2-cycle low pulse on rx: expect no byte and no error.
  - A following clean word loads normally.
- Wrap with ADDR_W=2: send 5 words.
  - Expect the 5th write at addr 0 and word_count_o = 5.
- Reset mid-frame: pull rst_l low during DATA bit 3.
  - Expect all outputs 0. A fresh word after reset is written at addr 0.
- With UART_PROG_LOADER_PARITY_EN defined: send 0x03 with parity 1.
  - Expect parity_err_o = 1 and the byte dropped.
